// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU-sharing arbiter.
package fpu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef logic [1:0] fpu_ins_t;

    localparam logic [31:0] FPU_QNAN = 32'h7FC00000;

endpackage

// File: rtl/fpu_rr_pick.sv
// Combinational rotate-priority picker: searches upward from last_grant+1
// (wrapping) and returns the first active requester as one-hot and index.
module fpu_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_grant_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        logic          found;
        logic [IW-1:0] pos;
        grant_o = '0;
        idx_o   = last_grant_i;
        found   = 1'b0;
        pos     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = IW'((int'(last_grant_i) + k) % NREQ);
            if (!found && req_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter/sequencer sharing one FPU among NREQ requesters.
// Optional WAIT watchdog enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_ins,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_data,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 fpu_enable,
    output fpu_ins_t             fpu_instruction,
    output logic [31:0]          fpu_ai,
    output logic [31:0]          fpu_bi,
    input  logic [31:0]          fpu_co,
    input  logic                 fpu_valid
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    fpu_ins_t        ins_q, ins_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [31:0]     resp_data_q, resp_data_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic            fpu_enable_q, fpu_enable_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    fpu_ins_t        ins_arr [NREQ];
    logic [31:0]     a_arr   [NREQ];
    logic [31:0]     b_arr   [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign ins_arr[gi] = req_ins[2*gi +: 2];
            assign a_arr[gi]   = req_a[32*gi +: 32];
            assign b_arr[gi]   = req_b[32*gi +: 32];
        end
    endgenerate

    fpu_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_grant),
        .idx_o        (pick_idx),
        .any_o        (pick_any)
    );

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          resp_err_q, resp_err_d;
`else
    // Without the watchdog TIMEOUT_CYC has no effect; the empty block only references it.
    if (TIMEOUT_CYC < 1) begin : g_tmo_unused
    end
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        ins_d        = ins_q;
        a_d          = a_q;
        b_d          = b_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = '0;
        fpu_enable_d = 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
        resp_err_d   = 1'b0;
        tmo_d        = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d      = ISSUE;
                    owner_d      = pick_idx;
                    last_grant_d = pick_idx;
                    ins_d        = ins_arr[pick_idx];
                    a_d          = a_arr[pick_idx];
                    b_d          = b_arr[pick_idx];
                    fpu_enable_d = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            WAIT: begin
                if (fpu_valid) begin
                    state_d      = RESP;
                    resp_data_d  = fpu_co;
                    resp_valid_d = NREQ'(1) << owner_q;
                end
`ifdef FPU_ARB_TIMEOUT_EN
                // Firing on TIMEOUT_CYC-1 makes resp_valid land TIMEOUT_CYC+2 cycles after accept.
                else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d      = RESP;
                    resp_data_d  = FPU_QNAN;
                    resp_err_d   = 1'b1;
                    resp_valid_d = NREQ'(1) << owner_q;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NREQ - 1);
            owner_q      <= '0;
            ins_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= '0;
            fpu_enable_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            ins_q        <= ins_d;
            a_q          <= a_d;
            b_q          <= b_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            fpu_enable_q <= fpu_enable_d;
            busy_q       <= busy_d;
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q      <= '0;
            resp_err_q <= 1'b0;
        end else begin
            tmo_q      <= tmo_d;
            resp_err_q <= resp_err_d;
        end
    end
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    // Accept is combinational so the requester sees its handshake in the same cycle.
    assign req_ready       = (state_q == IDLE && !rst) ? pick_grant : '0;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign busy            = busy_q;
    assign fpu_enable      = fpu_enable_q;
    assign fpu_instruction = ins_q;
    assign fpu_ai          = a_q;
    assign fpu_bi          = b_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with an XOR FPU stub of programmable latency.
module tb_fpu_arbiter;

    localparam int NREQ = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NREQ-1:0]  req_valid = '0;
    logic [2*NREQ-1:0] req_ins = '0;
    logic [32*NREQ-1:0] req_a = '0;
    logic [32*NREQ-1:0] req_b = '0;
    logic [NREQ-1:0]  req_ready;
    logic [NREQ-1:0]  resp_valid;
    logic [31:0]      resp_data;
    logic             resp_err;
    logic             busy;
    logic             fpu_enable;
    logic [1:0]       fpu_instruction;
    logic [31:0]      fpu_ai;
    logic [31:0]      fpu_bi;
    logic [31:0]      fpu_co;
    logic             fpu_valid;

    int checks = 0;
    int errors = 0;

    // FPU stub: co = ai ^ bi, valid L cycles after the enable cycle (lat==0: never)
    int   lat = 0;
    int   stub_cnt = 0;
    logic stray = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fpu_enable && lat != 0) stub_cnt <= lat;
        else if (stub_cnt != 0)     stub_cnt <= stub_cnt - 1;
    end
    assign fpu_valid = (stub_cnt == 1) || stray;
    assign fpu_co    = fpu_ai ^ fpu_bi;

    fpu_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ins         (req_ins),
        .req_a           (req_a),
        .req_b           (req_b),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .busy            (busy),
        .fpu_enable      (fpu_enable),
        .fpu_instruction (fpu_instruction),
        .fpu_ai          (fpu_ai),
        .fpu_bi          (fpu_bi),
        .fpu_co          (fpu_co),
        .fpu_valid       (fpu_valid)
    );

    function automatic int enc(logic [NREQ-1:0] v);
        int r = -1;
        int n = 0;
        for (int i = 0; i < NREQ; i++) if (v[i]) begin r = i; n++; end
        return (n == 1) ? r : -1;
    endfunction

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; stray = 1'b0; lat = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
        checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL reset_resp_valid: got %h expected 0", resp_valid); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fpu_enable !== 1'b0) begin errors++; $display("FAIL reset_fpu_enable: got %b expected 0", fpu_enable); end
        checks++; if ({fpu_instruction, fpu_ai, fpu_bi} !== 66'h0) begin errors++; $display("FAIL reset_fpu_operands: got %h %h %h expected 0", fpu_instruction, fpu_ai, fpu_bi); end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;
        $display("test_reset done");
    endtask

    task automatic test_single();
        reset_dut();
        lat = 3;
        req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000; req_ins[1:0] = 2'b10;
        req_valid = 4'b0001;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_accept: got %b expected 0001", req_ready); end
        @(posedge clk); #1; req_valid = '0;
        @(negedge clk);
        checks++; if (fpu_enable !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_issue: enable=%b busy=%b expected 1 1", fpu_enable, busy); end
        checks++; if (fpu_ai !== 32'h3F800000 || fpu_bi !== 32'h40000000 || fpu_instruction !== 2'b10) begin errors++; $display("FAIL single_operands: got %h %h %b", fpu_ai, fpu_bi, fpu_instruction); end
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk); #1; @(negedge clk);
            checks++;
            if (resp_valid !== ((k == 5) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL single_resp_valid_t%0d: got %b", k, resp_valid); end
            if (k == 2) begin
                checks++; if (fpu_enable !== 1'b0) begin errors++; $display("FAIL single_enable_pulse: got %b expected 0", fpu_enable); end
            end
            if (k == 5) begin
                checks++; if (resp_data !== 32'h7F800000 || resp_err !== 1'b0) begin errors++; $display("FAIL single_resp_data: got %h err=%b expected 7f800000 err=0", resp_data, resp_err); end
            end
            if (k == 6) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
            end
        end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        logic [31:0] va [NREQ];
        logic [31:0] vb [NREQ];
        int exp_order [5];
        int g_idx [$];
        int g_cyc [$];
        int r_idx [$];
        logic [31:0] r_dat [$];
        va = '{32'h3F800000, 32'h12345678, 32'hDEADBEEF, 32'h0F0F0F0F};
        vb = '{32'h40000000, 32'h00FF00FF, 32'h01234567, 32'hFFFF0000};
        exp_order = '{0, 1, 2, 3, 0};
        reset_dut();
        lat = 1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = va[i];
            req_b[32*i +: 32] = vb[i];
            req_ins[2*i +: 2] = 2'(i);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != 0) begin g_idx.push_back(enc(req_ready)); g_cyc.push_back(c); end
            if (resp_valid != 0) begin r_idx.push_back(enc(resp_valid)); r_dat.push_back(resp_data); end
            @(posedge clk); #1;
        end
        req_valid = '0;
        checks++; if (g_idx.size() != 5) begin errors++; $display("FAIL rr_grant_count: got %0d expected 5", g_idx.size()); end
        checks++; if (r_idx.size() != 5) begin errors++; $display("FAIL rr_resp_count: got %0d expected 5", r_idx.size()); end
        for (int j = 0; j < g_idx.size() && j < 5; j++) begin
            checks++; if (g_idx[j] != exp_order[j]) begin errors++; $display("FAIL rr_grant_%0d: got %0d expected %0d", j, g_idx[j], exp_order[j]); end
            if (j > 0) begin
                checks++; if (g_cyc[j] - g_cyc[j-1] != 4) begin errors++; $display("FAIL rr_gap_%0d: got %0d expected 4", j, g_cyc[j] - g_cyc[j-1]); end
            end
        end
        for (int j = 0; j < r_idx.size() && j < 5; j++) begin
            checks++;
            if (r_idx[j] != exp_order[j] || r_dat[j] !== (va[exp_order[j]] ^ vb[exp_order[j]])) begin
                errors++; $display("FAIL rr_resp_%0d: got idx %0d data %h expected idx %0d data %h", j, r_idx[j], r_dat[j], exp_order[j], va[exp_order[j]] ^ vb[exp_order[j]]);
            end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_rotation();
        int got [$];
        logic [NREQ-1:0] g;
        bit seen;
        reset_dut();
        lat = 2;
        req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rot_first_accept: got %b expected 0100", req_ready); end
        @(posedge clk); #1; req_valid = '0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (resp_valid != 0) seen = 1;
            @(posedge clk); #1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rot_first_resp: got none expected pulse within 20 cycles"); end
        req_valid = 4'b1010;
        for (int c = 0; c < 40 && got.size() < 2; c++) begin
            @(negedge clk);
            g = req_ready;
            if (g != 0) got.push_back(enc(g));
            @(posedge clk); #1;
            req_valid = req_valid & ~g;
        end
        req_valid = '0;
        checks++;
        if (got.size() != 2) begin errors++; $display("FAIL rot_grant_count: got %0d expected 2", got.size()); end
        else if (got[0] != 3 || got[1] != 1) begin errors++; $display("FAIL rot_order: got %0d,%0d expected 3,1", got[0], got[1]); end
        $display("test_rotation done");
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        reset_dut();
        lat = 10;
        req_a[31:0] = 32'hA5A5A5A5; req_b[31:0] = 32'h5A5A5A5A; req_ins[1:0] = 2'b11;
        req_valid = 4'b0001;
        @(posedge clk); #1; req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midwait_busy_before: got %b expected 1", busy); end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fpu_enable !== 1'b0 || resp_valid !== 4'b0 || resp_data !== 32'h0 || resp_err !== 1'b0 || req_ready !== 4'b0) begin
            errors++; $display("FAIL midwait_outputs: busy=%b en=%b rv=%b rd=%h err=%b rr=%b expected all 0", busy, fpu_enable, resp_valid, resp_data, resp_err, req_ready);
        end
        checks++; if ({fpu_instruction, fpu_ai, fpu_bi} !== 66'h0) begin errors++; $display("FAIL midwait_operands: got %b %h %h expected 0", fpu_instruction, fpu_ai, fpu_bi); end
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1; @(negedge clk);
            if (resp_valid != 0) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midwait_late_valid: got resp_valid pulse expected none"); end
        @(posedge clk); #1;
        req_valid = 4'b0011;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midwait_next_grant: got %b expected 0001", req_ready); end
        @(posedge clk); #1; req_valid = '0;
        $display("test_reset_mid_wait done");
    endtask

    task automatic test_stray_valid();
        bit bad;
        reset_dut();
        stray = 1'b1;
        @(posedge clk); #1; stray = 1'b0;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid != 0 || busy != 0 || fpu_enable != 0) bad = 1;
            @(posedge clk); #1;
        end
        checks++; if (bad) begin errors++; $display("FAIL stray_ignored: got activity after stray valid expected none"); end
        req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stray_still_idle: got %b expected 0010", req_ready); end
        @(posedge clk); #1; req_valid = '0;
        $display("test_stray_valid done");
    endtask

    task automatic test_no_valid();
        int first;
        reset_dut();
        lat = 0;
        req_a[31:0] = 32'h11111111; req_b[31:0] = 32'h22222222;
        req_valid = 4'b0001;
        first = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1; req_valid = '0;
            @(negedge clk);
            if (resp_valid != 0 && first < 0) begin
                first = k;
`ifdef FPU_ARB_TIMEOUT_EN
                checks++; if (resp_data !== 32'h7FC00000 || resp_err !== 1'b1 || resp_valid !== 4'b0001) begin errors++; $display("FAIL timeout_resp: got %h err=%b rv=%b expected 7fc00000 err=1 rv=0001", resp_data, resp_err, resp_valid); end
`endif
            end
        end
`ifdef FPU_ARB_TIMEOUT_EN
        checks++; if (first != 10) begin errors++; $display("FAIL timeout_cycle: got T+%0d expected T+10", first); end
`else
        checks++; if (first != -1) begin errors++; $display("FAIL wait_forever: got resp at T+%0d expected none", first); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_forever_busy: got %b expected 1", busy); end
`endif
        reset_dut();
        $display("test_no_valid done");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_rotation();
        test_reset_mid_wait();
        test_stray_valid();
        test_no_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
